// File: rtl/dff_arb_pkg.sv
// Shared definitions for the dff_reg_arbiter slice.
// Holds the arbiter state encoding, the default sizing constants and the
// one-hot helper used to build the registered grant vector.
package dff_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_N_REQ    = 4;
    localparam int unsigned DEF_WIDTH    = 8;
    localparam int unsigned DEF_MAX_HOLD = 4;
    localparam int unsigned MAX_N_REQ    = 8;

    // One-hot vector of MAX_N_REQ bits with bit idx set; callers slice
    // the low N_REQ bits.
    function automatic logic [MAX_N_REQ-1:0] onehot(input int unsigned idx);
        return {{(MAX_N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/dff_reg_arbiter_if.sv
// Bus bundle between the producer blocks and dff_reg_arbiter.
//   req    : per-requester level request
//   wdata  : packed write data, slice i belongs to requester i
//   gnt    : registered one-hot grant
//   busy   : high while a requester owns the register
//   owner  : index of current or last owner
//   Q1/Q2  : register contents and its bitwise complement
// master modport: producer side.  slave modport: arbiter side.
interface dff_reg_arbiter_if
    import dff_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned WIDTH = DEF_WIDTH
);
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       gnt;
    logic                   busy;
    logic [IDX_W-1:0]       owner;
    logic [WIDTH-1:0]       Q1;
    logic [WIDTH-1:0]       Q2;

    modport master (
        output req, wdata,
        input  gnt, busy, owner, Q1, Q2
    );

    modport slave (
        input  req, wdata,
        output gnt, busy, owner, Q1, Q2
    );

endinterface

// File: rtl/dff_reg_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
// Finds the first set bit of req searching upward from ptr, wrapping from
// N_REQ-1 back to 0.
//   req   : request vector
//   ptr   : search start index (0..N_REQ-1)
//   found : any request present
//   sel   : index of the selected request (0 when found=0)
module rr_picker #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] sel
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [2*N_REQ-1:0] req_shift;

    // Doubling the vector and shifting by ptr turns the wrapped search into
    // a plain lowest-bit-first scan.
    assign req_dbl   = {req, req};
    assign req_shift = req_dbl >> ptr;

    always_comb begin
        int unsigned idx;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!found && req_shift[k]) begin
                found = 1'b1;
                idx   = 32'(ptr) + k;
                if (idx >= N_REQ) begin
                    idx = idx - N_REQ;
                end
                sel = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/dff_reg_arbiter.sv
// dff_reg_arbiter: round-robin arbiter sharing one WIDTH-bit D register
// between N_REQ requesters.  The granted owner loads its wdata slice on
// every edge where it keeps req high; dropping req releases ownership,
// followed by exactly one IDLE cycle before the next grant.
//   CLK   : clock, rising edge
//   RST_n : asynchronous active-low reset
//   bus   : dff_reg_arbiter_if.slave (req, wdata, gnt, busy, owner, Q1, Q2)
// Build option HOLD_LIMIT_EN: when defined, ownership is forcibly released
// after MAX_HOLD granted loads; when undefined MAX_HOLD only participates
// in the parameter range check.
module dff_reg_arbiter
    import dff_arb_pkg::*;
#(
    parameter int unsigned N_REQ    = DEF_N_REQ,
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
    input logic              CLK,
    input logic              RST_n,
    dff_reg_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > MAX_N_REQ || MAX_HOLD < 1) begin : g_param_check
        $error("dff_reg_arbiter: N_REQ must be 2..8 and MAX_HOLD at least 1");
    end

    arb_state_e       state_q, state_n;
    logic [N_REQ-1:0] gnt_q, gnt_n;
    logic [IDX_W-1:0] owner_q, owner_n;
    logic [IDX_W-1:0] ptr_q, ptr_n;
    logic [WIDTH-1:0] q1_q;
    logic             load_en;

`ifdef HOLD_LIMIT_EN
    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_n;
`endif

    logic             found;
    logic [IDX_W-1:0] sel;
    logic [MAX_N_REQ-1:0] sel_oh;
    logic             owner_req;
    logic [WIDTH-1:0] owner_data;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (bus.req),
        .ptr   (ptr_q),
        .found (found),
        .sel   (sel)
    );

    assign sel_oh = onehot(32'(sel));

    // Owner's request bit and data slice, muxed by the registered owner.
    always_comb begin
        owner_req  = 1'b0;
        owner_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                owner_req  = bus.req[i];
                owner_data = bus.wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        logic release_now;
        state_n     = state_q;
        gnt_n       = gnt_q;
        owner_n     = owner_q;
        ptr_n       = ptr_q;
        load_en     = 1'b0;
        release_now = 1'b0;
`ifdef HOLD_LIMIT_EN
        hold_cnt_n  = hold_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_n = GRANT;
                    gnt_n   = sel_oh[N_REQ-1:0];
                    owner_n = sel;
`ifdef HOLD_LIMIT_EN
                    hold_cnt_n = '0;
`endif
                end
            end
            GRANT: begin
`ifdef HOLD_LIMIT_EN
                hold_cnt_n = hold_cnt_q + CNT_W'(1);
`endif
                if (owner_req) begin
                    load_en = 1'b1;
`ifdef HOLD_LIMIT_EN
                    // Last permitted load still happens on the release edge.
                    if (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) begin
                        release_now = 1'b1;
                    end
`endif
                end else begin
                    release_now = 1'b1;
                end
                if (release_now) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    ptr_n   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            q1_q    <= '0;
`ifdef HOLD_LIMIT_EN
            hold_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_n;
            gnt_q   <= gnt_n;
            owner_q <= owner_n;
            ptr_q   <= ptr_n;
            if (load_en) begin
                q1_q <= owner_data;
            end
`ifdef HOLD_LIMIT_EN
            hold_cnt_q <= hold_cnt_n;
`endif
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.busy  = (state_q == GRANT);
    assign bus.owner = owner_q;
    assign bus.Q1    = q1_q;
    assign bus.Q2    = ~q1_q;

endmodule

// File: doc/dff_reg_arbiter.md
Name: dff_reg_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one WIDTH-bit synchronous D flip-flop register between N_REQ requesters.
- Grants exclusive write ownership and loads the owner's data on each granted clock edge.
- Drives true (Q1) and complemented (Q2) register outputs, matching the existing D-FF datapath convention.
- Sits between several producer blocks and the shared state register.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, register data width.
- MAX_HOLD, 4, maximum consecutive granted cycles per ownership (active only with HOLD_LIMIT_EN).

Ports:
- CLK  input  1  clock, rising edge active.
- RST_n  input  1  reset, asynchronous, active-low.
- req  input  N_REQ  per-requester access request, level.
- wdata  input  N_REQ*WIDTH  packed write data; slice i belongs to requester i.
- gnt  output  N_REQ  one-hot grant, registered.
- busy  output  1  high while in GRANT state.
- owner  output  $clog2(N_REQ)  index of current or last owner.
- Q1  output  WIDTH  register contents.
- Q2  output  WIDTH  bitwise complement of Q1.

Behaviour:
- Reset state, asserted asynchronously while RST_n=0: state=IDLE, gnt=0, busy=0, owner=0, rr pointer ptr=0, hold_cnt=0, Q1=0, Q2=all ones.
- States: IDLE, GRANT.
- IDLE, no req: remain in IDLE with gnt=0.
- IDLE, any req bit set:
  - Select the first set bit searching upward from ptr, wrapping at N_REQ-1 to 0.
  - Next edge: gnt=onehot(sel), owner=sel, busy=1, hold_cnt=0, state=GRANT.
- GRANT, load: at each rising edge where req[owner]=1, Q1 <= wdata[owner]. Q1 is visible 1 cycle after the edge; latency req->gnt is 1 cycle and req->Q1 is 2 cycles.
- GRANT, count: hold_cnt increments on every edge spent in GRANT.
- GRANT, release conditions:
  - req[owner]=0 sampled: no load; next edge gnt=0, busy=0, state=IDLE, ptr=owner+1 mod N_REQ.
  - HOLD_LIMIT_EN defined and hold_cnt==MAX_HOLD-1 with req[owner]=1: final load happens on this edge, then release as above.
- After release there is always exactly one IDLE bubble cycle, even if requests are pending. No back-to-back grants.
- owner retains the last owner index in IDLE.
- Requests from non-owners during GRANT are ignored and do not affect Q1.
- Q2 is combinationally ~Q1 at all times, including during reset.
- Reset mid-GRANT: immediate clear to reset values. An in-flight load on the same edge is discarded.
- Invariant: gnt is never multi-hot; gnt!=0 if and only if busy=1.

Optional Feature:
- Macro HOLD_LIMIT_EN.
- Defined: ownership is forcibly released after MAX_HOLD granted cycles, so a requester holding req high is preempted and others are served round-robin.
- Undefined: MAX_HOLD is ignored; the owner keeps the grant until its req drops, and hold_cnt logic is removed.

Decomposition:
- Package dff_arb_pkg:
  - state enum {IDLE, GRANT}.
  - Default width/count constants.
  - Function onehot(idx).
- Sub-module rr_picker: combinational; inputs req and ptr, outputs found and sel index. Reusable for other shared resources.
- Top level holds the FSM, counters, and the data register.

Test Plan:
- Reset values: RST_n=0 -> gnt=0, busy=0, Q1=8'h00, Q2=8'hFF. Release RST_n mid-cycle -> no glitch on outputs.
- Single requester: req=4'b0100 at cycle 0, wdata[2]=8'hA5 -> gnt=4'b0100 at cycle 1, Q1=8'hA5 and Q2=8'h5A at cycle 2. Drop req at cycle 3 -> busy=0 at cycle 4, ptr=3.
- Round-robin: req=4'b1111 held constantly with HOLD_LIMIT_EN and MAX_HOLD=4 -> owners in order 0,1,2,3,0. Each owner gets 4 loads, separated by 1 IDLE cycle.
- Wrap-around: ptr=3, req=4'b0011 -> owner=0 granted, not 1.
- Non-owner isolation: owner=1 loading 8'h3C while req[0]=1 with wdata[0]=8'hFF -> Q1 stays 8'h3C.
- Async reset mid-GRANT: RST_n=0 while owner=2 and loading -> gnt=0 and Q1=0 immediately, without waiting for CLK. After release, arbitration restarts from ptr=0.
